toggle_stream_decoder: RTL
==========================

// Module: toggle_stream_decoder
// PURPOSE
//  Receive end of the toggle (T-type) line code: line_in changes level for a 1 and holds level for a 0.
//  The block recovers the bit stream with bit = line_in ^ previous line_in, then hunts for a sync word.
//  After sync it assembles fixed-length frames of W-bit words and delivers them on a valid/ready interface.
//  It sits between the serial line sampler and the word-level consumer logic.
// PARAMETERS
//  W          8      word width in bits; also the sync word width
//  SYNC_WORD  8'hA5  sync pattern, LSB received first; must be non-zero
//  FRAME_LEN  4      data words per frame after sync (>=1)
// PORTS
//  ck          in   1  clock; all state updates on rising edge
//  rst         in   1  synchronous reset, active high
//  en          in   1  sample strobe; line_in is sampled only when en=1
//  line_in     in   1  toggle-coded serial line
//  data_out    out  W  received word, LSB = first bit received
//  data_valid  out  1  data_out holds an unconsumed word
//  data_ready  in   1  consumer accepts data_out when data_valid & data_ready
//  sync_lock   out  1  1 while in LOCKED state
//  overrun     out  1  sticky: a completed word was dropped; cleared only by rst
// BEHAVIOUR
//  - Reset (rst=1 at an edge): line_prev=0, shift reg=0, state=HUNT, counters=0,
//    data_out=0, data_valid=0, sync_lock=0, overrun=0. Reset mid-frame discards everything.
//  - en=0: no state change except the output handshake (consumption still allowed).
//  - en=1: t_bit = line_in ^ line_prev; line_prev <= line_in; sr_next = {t_bit, sr[W-1:1]}.
//  - State HUNT: sr <= sr_next; if sr_next == SYNC_WORD -> LOCKED, bit_cnt=0, word_cnt=0.
//  - State LOCKED: shift t_bit into the assembly reg; bit_cnt++.
//    When bit_cnt reaches W-1 (the W-th bit): the word is complete; bit_cnt=0; word_cnt++.
//    When word_cnt reaches FRAME_LEN-1 (the last word): -> HUNT, sr=0, line_prev is kept.
//  - Word delivery: latency is 1 ck. data_out/data_valid update at the same edge that samples
//    the W-th bit.
//    Loaded if data_valid=0, or if data_valid & data_ready in the same cycle (the simultaneous
//    consume+load takes the new word, data_valid stays 1).
//    Otherwise the word is dropped, overrun<=1, and data_out keeps the old word.
//  - Consume: data_valid & data_ready with no new word -> data_valid<=0; data_out holds its value.
//  - data_ready is ignored while data_valid=0.
//  - The sync word is never delivered. No sync search occurs in LOCKED, even if data equals SYNC_WORD.
//  - sync_lock is a registered decode of the state: it is 1 from the edge entering LOCKED to the
//    edge leaving it.
// STRUCTURE
//  - Shared package toggle_pkg holds the state encoding (HUNT=0, LOCKED=1) and the default
//    W/SYNC_WORD/FRAME_LEN constants.
//  - One sub-module, toggle_edge_det (line_prev register + XOR, enable gated). It is the mirror
//    of the encoder's T flip-flop.
//  - The top level holds the FSM, the counters, the shift/assembly register and the output buffer.
// TESTING (W=8, SYNC_WORD=8'hA5, FRAME_LEN=2, en=1 every cycle unless stated)
//  1. Reset with rst=1 held for 2 ck -> all outputs 0, state HUNT; line_in activity during reset is
//     ignored.
//  2. Send t-bits for A5 (LSB first 1,0,1,0,0,1,0,1), then 3C, then 7E, with data_ready=1
//     -> sync_lock rises after the 8th bit; data_out=3C then 7E, each with a 1-ck valid pulse.
//     sync_lock falls after the 7E word.
//  3. Same frame with data_ready=0 -> first word 3C is held with valid=1; 7E is dropped; overrun=1;
//     data_out stays 3C. A later data_ready pulse clears valid.
//  4. data_ready asserted on the exact cycle the 2nd word completes -> 3C is consumed, 7E is loaded,
//     valid stays 1, overrun stays 0.
//  5. Garbage bits 1,1,0 then A5 -> lock only after the complete A5. A5 sent as payload while
//     LOCKED is delivered as data, not re-synced.
//  6. rst pulsed after 4 payload bits -> unlock, no word is output. A new A5+frame afterwards is
//     received correctly. en toggled 1/0 alternately gives identical results.

Source files
------------

// File: rtl/toggle_pkg.sv
// rtl/toggle_pkg.sv - shared state encoding and default parameters for the toggle stream decoder
package toggle_pkg;

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam int         DEF_W         = 8;
   localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
   localparam int         DEF_FRAME_LEN = 4;

endpackage

// File: rtl/toggle_stream_decoder_if.sv
// rtl/toggle_stream_decoder_if.sv - word output handshake between decoder and consumer
interface toggle_stream_decoder_if
   import toggle_pkg::*;
#(
   parameter int W = DEF_W
);

   logic [W-1:0] data_out;
   logic         data_valid;
   logic         data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/toggle_edge_det.sv
// rtl/toggle_edge_det.sv - recovers t-bits from the toggle line; mirror of the encoder T flip-flop
module toggle_edge_det (
   input  logic ck,
   input  logic rst,
   input  logic en,
   input  logic line_in,
   output logic t_bit
);

   logic line_prev_q;
   logic line_prev_d;

   always_comb begin
      line_prev_d = line_prev_q;
      if (en) begin
         line_prev_d = line_in;
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         line_prev_q <= 1'b0;
      end else begin
         line_prev_q <= line_prev_d;
      end
   end

   assign t_bit = line_in ^ line_prev_q;

endmodule

// File: rtl/toggle_stream_decoder.sv
// rtl/toggle_stream_decoder.sv - toggle line decoder: sync hunt, frame assembly, buffered word output
module toggle_stream_decoder
   import toggle_pkg::*;
#(
   parameter int           W         = DEF_W,
   parameter logic [W-1:0] SYNC_WORD = DEF_SYNC_WORD,
   parameter int           FRAME_LEN = DEF_FRAME_LEN
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     line_in,
   toggle_stream_decoder_if.master  dout,
   output logic                     sync_lock,
   output logic                     overrun
);

   localparam int BCW = (W > 1) ? $clog2(W) : 1;
   localparam int WCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_LEN - 1);

   logic           t_bit;
   logic [0:0]     state_q, state_d;
   logic [W-1:0]   sr_q, sr_d, sr_next;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic [W-1:0]   data_out_q, data_out_d;
   logic           data_valid_q, data_valid_d;
   logic           overrun_q, overrun_d;
   logic           sync_lock_q, sync_lock_d;
   logic           word_done;
   logic           consume;

   toggle_edge_det u_edge_det (
      .ck      (ck),
      .rst     (rst),
      .en      (en),
      .line_in (line_in),
      .t_bit   (t_bit)
   );

   // One shift register serves as the sync window in HUNT and the word assembler in LOCKED.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      overrun_d    = overrun_q;
      word_done    = 1'b0;
      sr_next      = {t_bit, sr_q[W-1:1]};
      consume      = data_valid_q & dout.data_ready;

      if (en) begin
         sr_d = sr_next;
         if (state_q == ST_HUNT) begin
            if (sr_next == SYNC_WORD) begin
               state_d    = ST_LOCKED;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
            end
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
               word_done = 1'b1;
               bit_cnt_d = '0;
               if (word_cnt_q == WORD_LAST) begin
                  state_d    = ST_HUNT;
                  sr_d       = '0;
                  word_cnt_d = '0;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
      end

      // A same-cycle consume frees the buffer, so the new word replaces it without a bubble.
      if (word_done) begin
         if (!data_valid_q || consume) begin
            data_out_d   = sr_next;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (consume) begin
         data_valid_d = 1'b0;
      end

      sync_lock_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         state_q      <= ST_HUNT;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         sync_lock_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
         sync_lock_q  <= sync_lock_d;
      end
   end

   assign dout.data_out   = data_out_q;
   assign dout.data_valid = data_valid_q;
   assign sync_lock       = sync_lock_q;
   assign overrun         = overrun_q;

endmodule
